id_hazard_ctrl: RTL
===================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 id_valid  input  1  decode stage holds a valid instruction this cycle.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the decode-stage instruction.
REQ-005 id_uses_rt  input  1  instruction reads id_rt (R-type, store, branch); rs is always read.
REQ-006 id_dst  input  5  destination register of the decode-stage instruction.
REQ-007 id_dst_we  input  1  decode-stage instruction writes id_dst.
REQ-008 id_jump  input  1  decode-stage instruction is a jump (target = {PC[31:28], 28-bit extended field}).
REQ-009 wb_we  input  1  writeback stage commits a register write this cycle.
REQ-010 wb_reg  input  5  register being written at writeback.
REQ-011 pc_write  output  1  program counter may advance.
REQ-012 ifid_write  output  1  IF/ID pipeline register may load.
REQ-013 idex_bubble  output  1  ID/EX register shall load a NOP instead of the decoded instruction.
REQ-014 ifid_flush  output  1  IF/ID register shall be cleared (wrong-path fetch).
REQ-015 state  output  2  current FSM state (00 RUN, 01 STALL, 10 FLUSH).

Function
REQ-016 Scoreboard: 32-bit pending vector, bit n = a write to register n is in flight; bit 0 never set.
REQ-017 hazard = id_valid and ((pending[id_rs] and id_rs!=0) or (id_uses_rt and pending[id_rt] and id_rt!=0)), evaluated after same-cycle writeback clear.
REQ-018 Writeback bypass: if wb_we and wb_reg equals a source register in the same cycle, that source is not hazardous (register file writes before read).
REQ-019 Issue: when id_valid, no hazard, FSM in RUN, and id_dst_we with id_dst!=0, set pending[id_dst] at the next edge.
REQ-020 Clear: wb_we clears pending[wb_reg] at the next edge; simultaneous issue and clear on the same register leaves the bit set.
REQ-021 RUN: hazard -> STALL; else id_jump -> FLUSH; else RUN.
REQ-022 STALL: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; stays while hazard holds; on hazard clear -> RUN (instruction issues in the RUN cycle).
REQ-023 FLUSH: lasts exactly one cycle; pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0; -> RUN unconditionally.
REQ-024 RUN outputs: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, except combinational override to STALL values in the cycle hazard is first detected.
REQ-025 Jump with hazard: stall first; jump flush occurs only after the hazard resolves.
REQ-026 id_valid=0: no hazard, no issue, no jump; FSM returns to/stays in RUN.
REQ-027 Outputs are a function of state and current inputs only; latency from hazard resolution to issue is zero cycles.

Reset
REQ-028 reset low asynchronously forces state=RUN, pending=0, and (when compiled in) stall_cycles=0.
REQ-029 During reset: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=1.
REQ-030 Reset asserted mid-STALL or mid-FLUSH discards the operation; first cycle after release is RUN with empty scoreboard.

Configuration
REQ-031 Macro ID_HAZARD_STALL_COUNT_EN, when defined, adds output stall_cycles (16 bits): increments every cycle idex_bubble=1 outside reset, saturates at 16'hFFFF, cleared only by reset.
REQ-032 Without ID_HAZARD_STALL_COUNT_EN the port and counter are absent; all other behaviour identical.

Verification
REQ-033 Issue write r5, next cycle decode reads rs=5 with no writeback -> state=STALL, pc_write=0, idex_bubble=1 until wb_we with wb_reg=5, then RUN same cycle.
REQ-034 Decode reads rt=7 with id_uses_rt=0 while pending[7]=1 -> no stall.
REQ-035 pending[3]=1, wb_we=1 wb_reg=3 and decode rs=3 in same cycle -> no stall (bypass).
REQ-036 id_jump=1, no hazard -> one FLUSH cycle with ifid_flush=1, then RUN.
REQ-037 Write to r0 issued then read rs=0 -> no stall; pending[0] remains 0.
REQ-038 Reset asserted during 3-cycle stall -> outputs immediately reset values; with macro defined, stall_cycles=0 after release; 70000 stall cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/id_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module     : id_hazard_ctrl_if
// Description: Decode/writeback inputs and pipeline-control outputs of the
//              decode-stage hazard controller. Carries stall_cycles when
//              ID_HAZARD_STALL_COUNT_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
interface id_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_dst;
    logic       id_dst_we;
    logic       id_jump;
    logic       wb_we;
    logic [4:0] wb_reg;

    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
    logic       ifid_flush;
    logic [1:0] state;

`ifdef ID_HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_dst_we, id_jump,
               wb_we, wb_reg,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, state, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_dst_we, id_jump,
               wb_we, wb_reg,
        output pc_write, ifid_write, idex_bubble, ifid_flush, state, stall_cycles
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_dst_we, id_jump,
               wb_we, wb_reg,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, state
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_dst_we, id_jump,
               wb_we, wb_reg,
        output pc_write, ifid_write, idex_bubble, ifid_flush, state
    );
`endif
endinterface
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : id_hazard_ctrl
// Description: Scoreboard-based RAW hazard detection and stall/flush control
//              for the decode stage. Optional stall counter enabled by
//              defining ID_HAZARD_STALL_COUNT_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    id_hazard_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [31:0] pending_q;
    logic [31:0] pending_d;

    logic [31:0] w_clr_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_eff_pending;
    logic        w_rs_haz;
    logic        w_rt_haz;
    logic        w_hazard;
    logic        w_issue;
    logic        w_pc_write;
    logic        w_ifid_write;
    logic        w_idex_bubble;
    logic        w_ifid_flush;

    // A same-cycle writeback is treated as already retired: the register
    // file writes before it is read, so the source is safe to consume.
    always_comb begin
        w_clr_mask = '0;
        if (bus.wb_we) begin
            w_clr_mask[bus.wb_reg] = 1'b1;
        end
        w_eff_pending = pending_q & ~w_clr_mask;
        w_rs_haz      = w_eff_pending[bus.id_rs] && (bus.id_rs != 5'd0);
        w_rt_haz      = bus.id_uses_rt && w_eff_pending[bus.id_rt]
                        && (bus.id_rt != 5'd0);
        w_hazard      = bus.id_valid && (w_rs_haz || w_rt_haz);
    end

    // STALL with the hazard gone behaves exactly like RUN so the waiting
    // instruction issues in the very cycle its operand becomes available.
    always_comb begin
        state_d       = state_q;
        w_issue       = 1'b0;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (w_hazard) begin
                    state_d       = ST_STALL;
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                end else begin
                    w_issue = bus.id_valid && bus.id_dst_we && (bus.id_dst != 5'd0);
                    state_d = (bus.id_valid && bus.id_jump) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                w_ifid_flush = 1'b1;
                state_d      = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Set is applied after clear so a same-register issue/retire keeps the bit.
    always_comb begin
        w_set_mask = '0;
        if (w_issue) begin
            w_set_mask[bus.id_dst] = 1'b1;
        end
        pending_d    = (pending_q & ~w_clr_mask) | w_set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign bus.pc_write    = rst_n ? w_pc_write    : 1'b0;
    assign bus.ifid_write  = rst_n ? w_ifid_write  : 1'b0;
    assign bus.idex_bubble = rst_n ? w_idex_bubble : 1'b1;
    assign bus.ifid_flush  = rst_n ? w_ifid_flush  : 1'b1;
    assign bus.state       = state_q;

`ifdef ID_HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (w_idex_bubble && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
`endif

endmodule
`default_nettype wire
